// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
package bp_pkg;

   // Default widths
   localparam int DBITS          = 32;
   localparam int PT_INDEX_BITS  = 8;
   localparam int BHR_BITS       = PT_INDEX_BITS;
   localparam int BTB_INDEX_BITS = 4;
   localparam int TAG_BITS       = DBITS - BTB_INDEX_BITS - 2;

   localparam int PT_ENTRIES     = 1 << PT_INDEX_BITS;
   localparam int BTB_ENTRIES    = 1 << BTB_INDEX_BITS;

   // Table sweep / normal operation
   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } bp_state_e;

   // 2-bit direction counter encoding; MSB set means "predict taken"
   localparam logic [1:0] SNT = 2'd0;
   localparam logic [1:0] WNT = 2'd1;
   localparam logic [1:0] WT  = 2'd2;
   localparam logic [1:0] ST  = 2'd3;

   // One BTB line
   typedef struct packed {
      logic                valid;
      logic [TAG_BITS-1:0] tag;
      logic [DBITS-1:0]    target;
   } btb_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state function of a 2-bit saturating direction counter.
module bp_sat_counter
   import bp_pkg::*;
(
   input  logic [1:0] cnt_i,
   input  logic       taken_i,
   output logic [1:0] cnt_o
);

   // Step toward ST on taken, toward SNT on not-taken, holding at either end
   always_comb begin
      cnt_o = cnt_i;
      case (cnt_i)
         SNT:     cnt_o = taken_i ? WNT : SNT;
         WNT:     cnt_o = taken_i ? WT  : SNT;
         WT:      cnt_o = taken_i ? ST  : WNT;
         ST:      cnt_o = taken_i ? ST  : WT;
         default: cnt_o = cnt_i;
      endcase
   end

endmodule

// File: rtl/fe_branch_predictor.sv
// Fetch-side gshare direction predictor with a direct-mapped BTB.
// Lookup is combinational from fetch_pc; training arrives from AGEX with the
// indices that were produced at fetch time. After reset a sweep initialises
// every table entry, one per cycle, while busy is held high.
module fe_branch_predictor
   import bp_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DBITS-1:0]          fetch_pc,
   output logic                      pred_taken,
   output logic [DBITS-1:0]          pred_target,
   output logic                      btb_hit,
   output logic [PT_INDEX_BITS-1:0]  pt_idx,
   output logic [BTB_INDEX_BITS-1:0] btb_idx,
   output logic                      busy,
   input  logic                      upd_valid,
   input  logic                      upd_is_branch,
   input  logic                      upd_taken,
   input  logic [DBITS-1:0]          upd_pc,
   input  logic [DBITS-1:0]          upd_target,
   input  logic [PT_INDEX_BITS-1:0]  upd_pt_idx,
   input  logic [BTB_INDEX_BITS-1:0] upd_btb_idx
);

   // Control state
   bp_state_e                 state_q, state_d;
   logic [PT_INDEX_BITS-1:0]  cnt_q, cnt_d;
   logic [BHR_BITS-1:0]       bhr_q, bhr_d;

   // Tables: no reset, initialised by the sweep instead
   logic [1:0]                pt_q  [PT_ENTRIES];
   btb_entry_t                btb_q [BTB_ENTRIES];

   // Single write port per table, shared between sweep and training
   logic                      pt_we;
   logic [PT_INDEX_BITS-1:0]  pt_waddr;
   logic [1:0]                pt_wdata;
   logic                      btb_we;
   logic [BTB_INDEX_BITS-1:0] btb_waddr;
   btb_entry_t                btb_wdata;

   logic                      upd_fire;
   logic [1:0]                upd_cnt_cur;
   logic [1:0]                upd_cnt_nxt;
   btb_entry_t                lookup_entry;
   logic [TAG_BITS-1:0]       lookup_tag;

   // Low PC bits carry no information for indexing or tagging
   logic                      unused_pc_bits;
   assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[BTB_INDEX_BITS+1:0]};

   assign upd_fire    = upd_valid & upd_is_branch;
   assign upd_cnt_cur = pt_q[upd_pt_idx];

   bp_sat_counter u_sat_counter (
      .cnt_i   (upd_cnt_cur),
      .taken_i (upd_taken),
      .cnt_o   (upd_cnt_nxt)
   );

   // ------------------------------------------------------------------
   // Lookup path (zero latency, asynchronous table reads)
   // ------------------------------------------------------------------
   assign pt_idx       = fetch_pc[PT_INDEX_BITS+1:2] ^ bhr_q;
   assign btb_idx      = fetch_pc[BTB_INDEX_BITS+1:2];
   assign lookup_tag   = fetch_pc[DBITS-1:BTB_INDEX_BITS+2];
   assign lookup_entry = btb_q[btb_idx];

   // Table contents are meaningless until the sweep completes, so a hit is
   // only reported in RUN.
   assign btb_hit     = (state_q == RUN) & lookup_entry.valid &
                        (lookup_entry.tag == lookup_tag);
   assign pred_target = btb_hit ? lookup_entry.target : '0;
   assign pred_taken  = (state_q == RUN) & btb_hit & pt_q[pt_idx][1];
   assign busy        = (state_q == INIT);

   // ------------------------------------------------------------------
   // Control
   // ------------------------------------------------------------------

   // Next-state: sweep progress, history shift, and table write selection
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      bhr_d            = bhr_q;
      pt_we            = 1'b0;
      pt_waddr         = upd_pt_idx;
      pt_wdata         = upd_cnt_nxt;
      btb_we           = 1'b0;
      btb_waddr        = upd_btb_idx;
      btb_wdata.valid  = 1'b1;
      btb_wdata.tag    = upd_pc[DBITS-1:BTB_INDEX_BITS+2];
      btb_wdata.target = upd_target;
      case (state_q)
         INIT: begin
            pt_we    = 1'b1;
            pt_waddr = cnt_q;
            pt_wdata = WNT;
            // BTB is smaller than the PT; only the first entries get cleared
            if (cnt_q < PT_INDEX_BITS'(BTB_ENTRIES)) begin
               btb_we    = 1'b1;
               btb_waddr = cnt_q[BTB_INDEX_BITS-1:0];
               btb_wdata = '0;
            end
            cnt_d = cnt_q + PT_INDEX_BITS'(1);
            if (cnt_q == PT_INDEX_BITS'(PT_ENTRIES - 1)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (upd_fire) begin
               pt_we  = 1'b1;
               bhr_d  = {bhr_q[BHR_BITS-2:0], upd_taken};
               // Not-taken outcomes never allocate or modify the BTB
               btb_we = upd_taken;
            end
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   // Control registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= INIT;
         cnt_q   <= '0;
         bhr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bhr_q   <= bhr_d;
      end
   end

   // Pattern table write port
   always_ff @(posedge clk) begin
      if (pt_we) begin
         pt_q[pt_waddr] <= pt_wdata;
      end
   end

   // BTB write port
   always_ff @(posedge clk) begin
      if (btb_we) begin
         btb_q[btb_waddr] <= btb_wdata;
      end
   end

endmodule
